// File: rtl/timer_reader.sv
// timer_reader: drives the timer's t_en from start/stop requests and reports
// the number of cycles t_en was high as the difference of two t_out snapshots.
module timer_reader #(
    parameter int TIMEOUT   = 16,
    parameter int MAX_TICKS = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        t_valid,
    input  logic [15:0] t_out,
    output logic        t_en,
    output logic        busy,
    output logic        done,
    output logic [15:0] elapsed,
    output logic        sat,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0] MT      = 16'(MAX_TICKS);

    state_t      state, state_n;
    logic [15:0] base, base_n, run_cnt, run_cnt_n, wd_cnt, wd_cnt_n, elapsed_n;
    logic        t_en_n, done_n, sat_n, sat_nxt, sat_nxt_n, err_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            t_en    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sat     <= 1'b0;
            sat_nxt <= 1'b0;
            err     <= 1'b0;
            elapsed <= '0;
            base    <= '0;
            run_cnt <= '0;
            wd_cnt  <= '0;
        end else begin
            state   <= state_n;
            t_en    <= t_en_n;
            busy    <= state_n != IDLE;
            done    <= done_n;
            sat     <= sat_n;
            sat_nxt <= sat_nxt_n;
            err     <= err_n;
            elapsed <= elapsed_n;
            base    <= base_n;
            run_cnt <= run_cnt_n;
            wd_cnt  <= wd_cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        t_en_n    = t_en;
        done_n    = 1'b0;
        sat_n     = sat;
        sat_nxt_n = sat_nxt;
        err_n     = err;
        elapsed_n = elapsed;
        base_n    = base;
        run_cnt_n = run_cnt;
        wd_cnt_n  = wd_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    base_n    = t_out;
                    run_cnt_n = '0;
                    wd_cnt_n  = '0;
                    err_n     = 1'b0;
                    t_en_n    = 1'b1;
                    state_n   = ARM;
                end
            end
            ARM: begin
                run_cnt_n = run_cnt + 16'd1;
                if (stop) begin
                    t_en_n    = 1'b0;
                    sat_nxt_n = 1'b0;
                    wd_cnt_n  = '0;
                    state_n   = DRAIN;
                end else if (t_valid) begin
                    state_n = RUN;
                end else if (wd_cnt == WD_LAST) begin
                    err_n   = 1'b1;
                    t_en_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    wd_cnt_n = wd_cnt + 16'd1;
                end
            end
            RUN: begin
                run_cnt_n = run_cnt + 16'd1;
                // t_valid falling while we still hold t_en means the timer is not following us
                if (!t_valid) begin
                    err_n   = 1'b1;
                    t_en_n  = 1'b0;
                    state_n = IDLE;
                end else if (stop || run_cnt + 16'd1 == MT) begin
                    t_en_n    = 1'b0;
                    sat_nxt_n = !stop;
                    wd_cnt_n  = '0;
                    state_n   = DRAIN;
                end
            end
            default: begin
                if (!t_valid) begin
                    elapsed_n = t_out - base;
                    sat_n     = sat_nxt;
                    done_n    = 1'b1;
                    state_n   = IDLE;
                end else if (wd_cnt == WD_LAST) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    wd_cnt_n = wd_cnt + 16'd1;
                end
            end
        endcase
    end
endmodule
